apb_slv: RTL
============

APB_SLV -- requirements
Module: apb_slv

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hDEADCAFE & 32'hFFFF_FFF0 (= 32'hDEADCAF0), base of the 16-byte register window.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states per access (range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port psel  input  1  slave select from master.
REQ-006 SHALL have port penable  input  1  access-phase strobe.
REQ-007 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-008 SHALL have port paddr  input  32  byte address.
REQ-009 SHALL have port pwdata  input  32  write data.
REQ-010 SHALL have port prdata  output  32  read data, valid only when pready=1 on a read; 0 otherwise.
REQ-011 SHALL have port pready  output  1  transfer-complete; combinational from state/counter.
REQ-012 SHALL have port pslverr  output  1  error flag, valid only when pready=1; 0 otherwise.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-014 IDLE->SETUP when psel=1 and penable=0; SETUP->ACCESS when psel=1 and penable=1; SETUP->IDLE if psel drops.
REQ-015 On SETUP entry, SHALL load the wait counter with WAIT_CYCLES and capture paddr, pwrite and pwdata.
REQ-016 In ACCESS, the counter SHALL decrement each cycle while nonzero; pready=1 exactly when the counter is 0.
REQ-017 ACCESS with pready=1 SHALL exit to SETUP if psel=1 and penable=0 on that edge (back-to-back), else to IDLE.
REQ-018 penable=1 while in IDLE (protocol violation) SHALL complete immediately: pready=1, pslverr=1, no register change.
REQ-019 Decode: hit when paddr[31:4]==BASE_ADDR[31:4] and paddr[1:0]==0; word index = paddr[3:2].
REQ-020 Register map: 0x0 CTRL RW (reset 0); 0x4 DATA RW (reset 0); 0x8 STATUS RO = {16'b0, wr_cnt}; 0xC ID RO = 32'hA9B50001.
REQ-021 A write SHALL take effect on the rising edge at which pready=1; never earlier.
REQ-022 wr_cnt SHALL increment by 1 per successful RW write and wrap from 16'hFFFF to 0.
REQ-023 pslverr=1 for a miss, a misaligned address, or a write to STATUS/ID; such writes SHALL NOT change state or wr_cnt.
REQ-024 A read miss SHALL return prdata=0 with pslverr=1.
REQ-025 Latency: pready SHALL rise WAIT_CYCLES cycles after ACCESS entry (same cycle when WAIT_CYCLES=0).

Reset
REQ-026 rst=0 SHALL force IDLE, counter 0, CTRL=0, DATA=0, wr_cnt=0 and pready=0, pslverr=0, prdata=0 immediately, including mid-transfer; any pending write is dropped.

Configuration
REQ-027 With macro APB_SLV_WAIT_EN defined, wait states follow WAIT_CYCLES; without it, the counter SHALL be absent and pready=1 on the first ACCESS cycle regardless of WAIT_CYCLES.

Structure
REQ-028 A shared package apb_pkg SHALL hold the state encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10), register offsets and the ID constant.
REQ-029 The register file and decode SHALL be one sub-module apb_slv_regs; the FSM and wait counter SHALL stay in apb_slv.

Verification
REQ-030 Write 0x12345678 to 0xDEADCAF4, WAIT_CYCLES=2 -> pready low for 2 ACCESS cycles, then high; read-back returns 0x12345678, pslverr=0.
REQ-031 Read 0xDEADCAFC -> prdata=0xA9B50001, pslverr=0.
REQ-032 Write to 0xDEADCAF8 and to 0x00000000 -> pslverr=1 on both; STATUS unchanged.
REQ-033 Three back-to-back writes (SETUP directly after the completing ACCESS) -> no IDLE between them; STATUS=3.
REQ-034 rst asserted during ACCESS of a write to CTRL -> CTRL stays 0; pready=0 immediately; FSM in IDLE.
REQ-035 Build without APB_SLV_WAIT_EN -> every transfer completes in 2 cycles (SETUP plus one ACCESS cycle).

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg
//   Shared definitions for the APB slave: FSM state encoding, register
//   word offsets (paddr[3:2]) and the fixed ID register value.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam logic [1:0]  REG_CTRL   = 2'd0;
  localparam logic [1:0]  REG_DATA   = 2'd1;
  localparam logic [1:0]  REG_STATUS = 2'd2;
  localparam logic [1:0]  REG_ID     = 2'd3;

  localparam logic [31:0] ID_VALUE   = 32'hA9B5_0001;

endpackage

// File: rtl/apb_slv_regs.sv
// apb_slv_regs
//   Address decode and register file behind the APB slave.
//   Map (word index = addr[3:2]): CTRL RW, DATA RW, STATUS RO {16'b0, wr_cnt},
//   ID RO constant.
// Ports:
//   clk, rst        clock, async active-low reset
//   addr, wr, wdata transfer captured at SETUP entry
//   done            transfer completes on this rising edge
//   rdata           read data for the decoded word (0 on a miss)
//   err             miss, misaligned access, or write to a read-only word
module apb_slv_regs
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hDEADCAF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  logic        hit;
  logic [1:0]  idx;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] data_q, data_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    hit = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
    idx = addr[3:2];
    err = !hit || (wr && (idx == REG_STATUS || idx == REG_ID));
  end

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (idx)
        REG_CTRL:   rdata = ctrl_q;
        REG_DATA:   rdata = data_q;
        REG_STATUS: rdata = {16'd0, wr_cnt_q};
        default:    rdata = ID_VALUE;
      endcase
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    data_d   = data_q;
    wr_cnt_d = wr_cnt_q;
    // err already excludes read-only words, so only CTRL/DATA reach here.
    if (done && wr && !err) begin
      if (idx == REG_CTRL) ctrl_d = wdata;
      else                 data_d = wdata;
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= 32'd0;
      data_q   <= 32'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      ctrl_q   <= ctrl_d;
      data_q   <= data_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

endmodule

// File: rtl/apb_slv.sv
// apb_slv
//   APB slave with a 16-byte register window at BASE_ADDR and optional wait
//   states. Wait states exist only when APB_SLV_WAIT_EN is defined; otherwise
//   every transfer completes on its first ACCESS cycle.
// Ports:
//   clk, rst                 clock, async active-low reset
//   psel, penable, pwrite    APB control
//   paddr, pwdata            APB address / write data
//   prdata, pready, pslverr  APB response (all 0 unless pready=1)
//
// state  | meaning
// IDLE   | no transfer; penable here is answered at once with an error
// SETUP  | address phase, transfer captured, counter loaded
// ACCESS | waiting for the counter to hit 0, completes with pready=1
module apb_slv
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hDEADCAFE & 32'hFFFF_FFF0,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  apb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        load;
  logic        xfer_ready;
  logic        done;
  logic [31:0] reg_rdata;
  logic        reg_err;

`ifdef APB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q, cnt_d;

  assign xfer_ready = (cnt_q == 4'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (load)                                    cnt_d = WAIT_LD;
    else if (state_q == ACCESS && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 4'd0;
    else      cnt_q <= cnt_d;
  end
`else
  assign xfer_ready = 1'b1;
`endif

  assign done = (state_q == ACCESS) && xfer_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = SETUP;
          load    = 1'b1;
        end
      end
      SETUP: begin
        if (!psel)        state_d = IDLE;
        else if (penable) state_d = ACCESS;
      end
      ACCESS: begin
        if (xfer_ready) begin
          if (psel && !penable) begin
            state_d = SETUP;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    if (load) begin
      addr_d  = paddr;
      wr_d    = pwrite;
      wdata_d = pwdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  // Gated by rst so the response is silenced the moment reset asserts, even
  // while a stray penable would otherwise hit the IDLE error path.
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'd0;
    if (rst) begin
      if (done) begin
        pready  = 1'b1;
        pslverr = reg_err;
        prdata  = wr_q ? 32'd0 : reg_rdata;
      end else if (state_q == IDLE && penable) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end
    end
  end

  apb_slv_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr_q),
    .wr    (wr_q),
    .wdata (wdata_q),
    .done  (done),
    .rdata (reg_rdata),
    .err   (reg_err)
  );

endmodule
